uart_top: RTL and testbench



---
 rtl/uart_top.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: full-duplex UART (one transmitter, one receiver) with a shared
// clock-derived bit period of DIV = CLK_FREQ/BAUD_RATE cycles.
// Optional feature: define UART_RX_ERR_EN to add the rx_err output, which pulses
// for one cycle when a received frame has a stop-bit or parity error.
module uart_top #(
  parameter int   CLK_FREQ    = 50000000,
  parameter int   SINGLE_SEND = 1,
  parameter int   ARCH_SEL    = 0,
  parameter int   BAUD_RATE   = 9600,
  parameter int   BIT_WIDTH   = 8,
  parameter logic START_BIT   = 1'b0,
  parameter int   LSB_TO_MSB  = 1,
  parameter int   PARITY_SEL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic                 read,
  output logic                 busy,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  output logic [BIT_WIDTH-1:0] rx_reg,
  input  logic [BIT_WIDTH-1:0] tx_reg
`ifdef UART_RX_ERR_EN
  ,
  output logic                 rx_err
`endif
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  // PARITY_SEL values other than 1/2 (including the illegal 3) mean no parity
  localparam logic PAR_EN  = (PARITY_SEL == 1) || (PARITY_SEL == 2);
  localparam logic PAR_ODD = (PARITY_SEL == 2);
  // With 3-sample voting the window is centred one cycle before the
  // sample edge, so the first sample is taken one cycle later.
  localparam int HALF = (DIV / 2) + ((ARCH_SEL == 1) ? 1 : 0);

  localparam logic            STOP_LVL = ~START_BIT;
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(BIT_WIDTH - 1);

  // Parity bit value for a data word (even = XOR of bits, odd = inverse)
  function automatic logic parity_f(input logic [BIT_WIDTH-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Majority vote of three samples
  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bit position in the word for the idx-th serial bit
  function automatic logic [IW-1:0] pos_f(input logic [IW-1:0] idx);
    logic [IW-1:0] p;
    if (LSB_TO_MSB == 1) p = idx;
    else                 p = IDX_LAST - idx;
    return p;
  endfunction

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic [BIT_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                 send_prev_q, send_prev_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 busy_q, busy_d;
  logic                 tx_req_s;
  logic                 tx_tick_s;

  // TX state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= CNT_ZERO;
      tx_idx_q    <= IDX_ZERO;
      tx_data_q   <= {BIT_WIDTH{1'b0}};
      send_prev_q <= 1'b0;
      tx_pin_q    <= STOP_LVL;
      busy_q      <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      send_prev_q <= send_prev_d;
      tx_pin_q    <= tx_pin_d;
      busy_q      <= busy_d;
    end
  end

  // TX next state: request acceptance, bit timing and bit sequencing
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    send_prev_d = send;
    tx_tick_s   = (tx_cnt_q == CNT_LAST);
    if (SINGLE_SEND == 1) tx_req_s = send & ~send_prev_q;
    else                  tx_req_s = send;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = CNT_ZERO;
        if (tx_req_s) begin
          tx_state_d = TX_START;
          tx_idx_d   = IDX_ZERO;
          tx_data_d  = tx_reg;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick_s) begin
          tx_cnt_d   = CNT_ZERO;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_tick_s) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_idx_q == IDX_LAST) begin
            if (PAR_EN) tx_state_d = TX_PAR;
            else        tx_state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + IDX_ONE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_PAR: begin
        if (tx_tick_s) begin
          tx_cnt_d   = CNT_ZERO;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_tick_s) begin
          tx_cnt_d   = CNT_ZERO;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // TX outputs decoded from the next state so the pin and busy are registered
  always_comb begin
    busy_d = (tx_state_d != TX_IDLE);
    case (tx_state_d)
      TX_IDLE:  tx_pin_d = STOP_LVL;
      TX_START: tx_pin_d = START_BIT;
      TX_DATA:  tx_pin_d = tx_data_d[pos_f(tx_idx_d)];
      TX_PAR:   tx_pin_d = parity_f(tx_data_d);
      TX_STOP:  tx_pin_d = STOP_LVL;
      default:  tx_pin_d = STOP_LVL;
    endcase
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic [BIT_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_ok_q, rx_par_ok_d;
  logic [BIT_WIDTH-1:0] rx_reg_q, rx_reg_d;
  logic                 sync1_q, sync2_q, hist1_q, hist2_q;
  logic                 rx_smp_s;
  logic                 rx_tick_s;
  logic                 rx_stop_evt_s;
  logic                 rx_good_s;

  // RX synchronizer, sample history, state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= STOP_LVL;
      sync2_q     <= STOP_LVL;
      hist1_q     <= STOP_LVL;
      hist2_q     <= STOP_LVL;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= CNT_ZERO;
      rx_idx_q    <= IDX_ZERO;
      rx_data_q   <= {BIT_WIDTH{1'b0}};
      rx_par_ok_q <= 1'b1;
      rx_reg_q    <= {BIT_WIDTH{1'b0}};
    end else begin
      sync1_q     <= rx_pin;
      sync2_q     <= sync1_q;
      hist1_q     <= sync2_q;
      hist2_q     <= hist1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_data_q   <= rx_data_d;
      rx_par_ok_q <= rx_par_ok_d;
      rx_reg_q    <= rx_reg_d;
    end
  end

  // RX bit sample: single synchronized value or 3-sample vote
  always_comb begin
    if (ARCH_SEL == 1) rx_smp_s = maj3_f(sync2_q, hist1_q, hist2_q);
    else               rx_smp_s = sync2_q;
  end

  // RX next state: start detection, glitch rejection, bit assembly
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_data_d   = rx_data_q;
    rx_par_ok_d = rx_par_ok_q;
    rx_tick_s   = (rx_cnt_q == CNT_LAST);
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (sync2_q == START_BIT) rx_state_d = RX_START;
        else                      rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = CNT_ZERO;
          if (rx_smp_s == START_BIT) begin
            rx_state_d  = RX_DATA;
            rx_idx_d    = IDX_ZERO;
            rx_par_ok_d = 1'b1;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_tick_s) begin
          rx_cnt_d = CNT_ZERO;
          rx_data_d[pos_f(rx_idx_q)] = rx_smp_s;
          if (rx_idx_q == IDX_LAST) begin
            if (PAR_EN) rx_state_d = RX_PAR;
            else        rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IDX_ONE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_PAR: begin
        if (rx_tick_s) begin
          rx_cnt_d    = CNT_ZERO;
          rx_par_ok_d = (rx_smp_s == parity_f(rx_data_q));
          rx_state_d  = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_tick_s) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // RX outputs: frame check at the stop sample and gated word update
  always_comb begin
    rx_stop_evt_s = (rx_state_q == RX_STOP) && rx_tick_s;
    rx_good_s     = (rx_smp_s == STOP_LVL) && rx_par_ok_q;
    if (rx_stop_evt_s && rx_good_s && read) rx_reg_d = rx_data_q;
    else                                    rx_reg_d = rx_reg_q;
  end

`ifdef UART_RX_ERR_EN
  logic rx_err_q, rx_err_d;

  // Error pulse at a stop sample that fails the stop-bit or parity check
  always_comb begin
    if (rx_stop_evt_s && !rx_good_s) rx_err_d = 1'b1;
    else                             rx_err_d = 1'b0;
  end

  // Error pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_err_q <= 1'b0;
    else     rx_err_q <= rx_err_d;
  end

  assign rx_err = rx_err_q;
`endif

  assign tx_pin = tx_pin_q;
  assign busy   = busy_q;
  assign rx_reg = rx_reg_q;

endmodule

// File: tb/tb_uart_top.sv
// Directed loopback bench for uart_top with DIV = 160/10 = 16.
// dut_a: single-send, no parity. dut_b: repeat-send, no parity.
// dut_c: single-send, even parity. Each rx_pin is its tx_pin ANDed with
// a bench-controlled force-low, used for glitches and corrupted bits.
module tb_uart_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       read;
  logic [7:0] tx_reg;
  logic       send_a, send_b, send_c;
  logic       frc_a, frc_b, frc_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       rxp_a, rxp_b, rxp_c;
  logic [7:0] rx_reg_a, rx_reg_b, rx_reg_c;
`ifdef UART_RX_ERR_EN
  logic       err_a, err_b, err_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic       cap_tx   [0:699];
  logic       cap_busy [0:699];
  logic [7:0] cap_rx   [0:699];
  logic       cap_err  [0:699];

  assign rxp_a = tx_a & ~frc_a;
  assign rxp_b = tx_b & ~frc_b;
  assign rxp_c = tx_c & ~frc_c;

  always #5 clk = ~clk;

  uart_top #(.CLK_FREQ(160), .BAUD_RATE(10), .SINGLE_SEND(1), .PARITY_SEL(0)) u_dut_a (
    .clk(clk), .rst(rst), .send(send_a), .read(read), .busy(busy_a),
    .rx_pin(rxp_a), .tx_pin(tx_a), .rx_reg(rx_reg_a), .tx_reg(tx_reg)
`ifdef UART_RX_ERR_EN
    , .rx_err(err_a)
`endif
  );

  uart_top #(.CLK_FREQ(160), .BAUD_RATE(10), .SINGLE_SEND(0), .PARITY_SEL(0)) u_dut_b (
    .clk(clk), .rst(rst), .send(send_b), .read(read), .busy(busy_b),
    .rx_pin(rxp_b), .tx_pin(tx_b), .rx_reg(rx_reg_b), .tx_reg(tx_reg)
`ifdef UART_RX_ERR_EN
    , .rx_err(err_b)
`endif
  );

  uart_top #(.CLK_FREQ(160), .BAUD_RATE(10), .SINGLE_SEND(1), .PARITY_SEL(1)) u_dut_c (
    .clk(clk), .rst(rst), .send(send_c), .read(read), .busy(busy_c),
    .rx_pin(rxp_c), .tx_pin(tx_c), .rx_reg(rx_reg_c), .tx_reg(tx_reg)
`ifdef UART_RX_ERR_EN
    , .rx_err(err_c)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_send(input int sel, input logic v);
    case (sel)
      1:       send_b = v;
      2:       send_c = v;
      default: send_a = v;
    endcase
  endtask

  task automatic set_frc(input int sel, input logic v);
    case (sel)
      1:       frc_b = v;
      2:       frc_c = v;
      default: frc_a = v;
    endcase
  endtask

  // Called at a negedge. Index i holds the outputs seen at the negedge after
  // the i-th posedge from the call; send is first sampled at posedge 0.
  task automatic run(input int sel, input logic [7:0] data, input int n, input int hold,
                     input int chg_at, input logic [7:0] chg_val, input int p2_at,
                     input int frc_from, input int frc_to);
    tx_reg = data;
    if (hold > 0) set_send(sel, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        1:       begin cap_tx[i] = tx_b; cap_busy[i] = busy_b; cap_rx[i] = rx_reg_b; end
        2:       begin cap_tx[i] = tx_c; cap_busy[i] = busy_c; cap_rx[i] = rx_reg_c; end
        default: begin cap_tx[i] = tx_a; cap_busy[i] = busy_a; cap_rx[i] = rx_reg_a; end
      endcase
`ifdef UART_RX_ERR_EN
      case (sel)
        1:       cap_err[i] = err_b;
        2:       cap_err[i] = err_c;
        default: cap_err[i] = err_a;
      endcase
`else
      cap_err[i] = 1'b0;
`endif
      if (i == hold - 1) set_send(sel, 1'b0);
      if (i == chg_at) tx_reg = chg_val;
      if (p2_at >= 0 && i == p2_at) set_send(sel, 1'b1);
      if (p2_at >= 0 && i == p2_at + 1) set_send(sel, 1'b0);
      set_frc(sel, (i >= frc_from) && (i < frc_to));
    end
  endtask

  function automatic int rises(input int n);
    int r = 0;
    logic prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cap_busy[i] && !prev) r++;
      prev = cap_busy[i];
    end
    return r;
  endfunction

  function automatic int err_cycles(input int n);
    int r = 0;
    for (int i = 0; i < n; i++) if (cap_err[i]) r++;
    return r;
  endfunction

  // Expected 0xA5 frame, LSB-first, one entry per bit period:
  // start 0, data 1,0,1,0,0,1,0,1, stop 1
  logic [9:0] a5_frame = 10'b1_1010_0101_0;

  initial begin
    rst = 1'b1; read = 1'b1; tx_reg = 8'h00;
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
    frc_a = 1'b0; frc_b = 1'b0; frc_c = 1'b0;

    // Reset state
    repeat (10) @(negedge clk);
    check_eq("rst_tx_pin", tx_a, 1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_rx_reg", rx_reg_a, 8'h00);
    check_eq("rst_tx_pin_c", tx_c, 1);
    check_eq("rst_rx_reg_b", rx_reg_b, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rel_tx_pin", tx_a, 1);
    check_eq("rel_busy", busy_a, 0);
    check_eq("rel_rx_reg", rx_reg_a, 8'h00);

    // Basic 0xA5 frame, send pulsed for one cycle
    check_eq("basic_busy_before", busy_a, 0);
    run(0, 8'hA5, 200, 1, -1, 8'h00, -1, -1, -1);
    check_eq("basic_busy_first", cap_busy[0], 1);
    for (int k = 0; k < 10; k++)
      check_eq($sformatf("basic_bit%0d", k), cap_tx[16*k+8], a5_frame[k]);
    check_eq("basic_busy_last", cap_busy[159], 1);
    check_eq("basic_busy_fall", cap_busy[160], 0);
    check_eq("basic_rx_before_stop", cap_rx[150], 8'h00);
    check_eq("basic_rx_after_stop", cap_rx[158], 8'hA5);
    check_eq("basic_frames", rises(200), 1);

    // Second send pulse 40 cycles into a frame is ignored
    run(0, 8'h96, 400, 1, -1, 8'h00, 40, -1, -1);
    check_eq("busy_send_frames", rises(400), 1);
    check_eq("busy_send_rx", cap_rx[399], 8'h96);

    // Single-send: send held 500 cycles, tx_reg changed mid-frame
    run(0, 8'hA5, 700, 500, 50, 8'h3C, -1, -1, -1);
    check_eq("ss1_hold_frames", rises(700), 1);
    check_eq("ss1_hold_gap", cap_busy[161], 0);
    check_eq("ss1_hold_rx", cap_rx[699], 8'hA5);

    // Repeat-send: send held 450 cycles -> frames start at 0, 161, 322
    run(1, 8'hA5, 650, 450, 50, 8'h3C, -1, -1, -1);
    check_eq("ss0_frames", rises(650), 3);
    check_eq("ss0_gap_low", cap_busy[160], 0);
    check_eq("ss0_gap_restart", cap_busy[161], 1);
    check_eq("ss0_rx_frame1", cap_rx[158], 8'hA5);
    check_eq("ss0_f2_bit0", cap_tx[185], 0);
    check_eq("ss0_f2_bit2", cap_tx[217], 1);
    check_eq("ss0_rx_frame2", cap_rx[319], 8'h3C);
    check_eq("ss0_f3_bit0", cap_tx[346], 0);
    check_eq("ss0_end_idle", cap_busy[482], 0);

    // Even parity, 0x07 -> parity bit 1, frame 176 cycles
    run(2, 8'h07, 200, 1, -1, 8'h00, -1, -1, -1);
    check_eq("par_bit7", cap_tx[136], 0);
    check_eq("par_bit", cap_tx[152], 1);
    check_eq("par_stop", cap_tx[168], 1);
    check_eq("par_busy_last", cap_busy[175], 1);
    check_eq("par_busy_fall", cap_busy[176], 0);
    check_eq("par_rx", cap_rx[199], 8'h07);
`ifdef UART_RX_ERR_EN
    check_eq("par_err_none", err_cycles(200), 0);
`endif

    // 0x01 with its parity bit forced low on rx_pin -> rejected
    run(2, 8'h01, 200, 1, -1, 8'h00, -1, 146, 162);
    check_eq("parerr_tx_bit", cap_tx[152], 1);
    check_eq("parerr_rx_held", cap_rx[199], 8'h07);
`ifdef UART_RX_ERR_EN
    check_eq("parerr_err_pulse", err_cycles(200), 1);
`endif

    // read = 0 during a 0x5A frame -> rx_reg keeps 0xA5
    read = 1'b0;
    run(0, 8'h5A, 200, 1, -1, 8'h00, -1, -1, -1);
    read = 1'b1;
    check_eq("read0_frames", rises(200), 1);
    check_eq("read0_rx_held", cap_rx[199], 8'hA5);

    // 3-cycle low glitch -> no reception, then a real frame still works
    run(0, 8'h00, 60, 0, -1, 8'h00, -1, 5, 8);
    check_eq("glitch_no_tx", rises(60), 0);
    check_eq("glitch_rx_held", cap_rx[59], 8'hA5);
    run(0, 8'h81, 200, 1, -1, 8'h00, -1, -1, -1);
    check_eq("post_glitch_rx", cap_rx[199], 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
